ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It is the send side of the existing ps2_keyboard receiver and lets the game controller send keyboard commands such as 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset). It drives the open-collector clock and data lines through active-high pull-low enables. It also tells the receiver when to stop sampling so the host's own frame is not captured as a scancode.

---
 rtl/ps2_host_tx_if.sv | 23 ++
 rtl/ps2_host_tx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// Signal bundle between the game controller, the PS/2 pads and the host transmitter.
// "slave" is the transmitter's view; "master" is the controller/pad side.
interface ps2_host_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       tx_idle;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output wr_ps2, din, ps2c_in, ps2d_in,
        input  ps2c_oe, ps2d_oe, tx_idle, tx_done, tx_err
    );

    modport slave (
        input  wr_ps2, din, ps2c_in, ps2d_in,
        output ps2c_oe, ps2d_oe, tx_idle, tx_done, tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame clocked by the
// device, ACK check, watchdog. Lines are driven as active-high pull-low enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave bus
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RTS     = 3'd1;
    localparam logic [2:0] START   = 3'd2;
    localparam logic [2:0] DATA    = 3'd3;
    localparam logic [2:0] STOP    = 3'd4;
    localparam logic [2:0] RECOVER = 3'd5;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    logic                  ps2c_p0, ps2c_p1, ps2d_p0, ps2d_p1;
    logic [FILTER_LEN-1:0] filt_p2;
    logic                  filt_clk, fall;

    logic [2:0]       state;
    logic [8:0]       shreg;
    logic [INH_W-1:0] inh_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic [3:0]       bit_cnt;
    logic             ack_ok;
    logic             ps2c_oe_r, ps2d_oe_r, tx_idle_r, tx_done_r, tx_err_r;

    // Stage p0/p1: synchronisers; stage p2: clock glitch filter and fall detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps2c_p0  <= 1'b0;
            ps2c_p1  <= 1'b0;
            ps2d_p0  <= 1'b0;
            ps2d_p1  <= 1'b0;
            filt_p2  <= '0;
            filt_clk <= 1'b0;
            fall     <= 1'b0;
        end else begin
            ps2c_p0  <= bus.ps2c_in;
            ps2c_p1  <= ps2c_p0;
            ps2d_p0  <= bus.ps2d_in;
            ps2d_p1  <= ps2d_p0;
            filt_p2  <= {filt_p2[FILTER_LEN-2:0], ps2c_p1};
            if (&filt_p2)
                filt_clk <= 1'b1;
            else if (~|filt_p2)
                filt_clk <= 1'b0;
            fall     <= filt_clk & ~|filt_p2;
        end
    end

    // Transmit sequencer; all outputs registered alongside the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            inh_cnt   <= '0;
            wd_cnt    <= '0;
            bit_cnt   <= '0;
            ack_ok    <= 1'b0;
            ps2c_oe_r <= 1'b0;
            ps2d_oe_r <= 1'b0;
            tx_idle_r <= 1'b1;
            tx_done_r <= 1'b0;
            tx_err_r  <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            tx_err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_ps2) begin
                        shreg     <= {odd_parity(bus.din), bus.din};
                        inh_cnt   <= INH_W'(INHIBIT_CYCLES - 1);
                        state     <= RTS;
                        ps2c_oe_r <= 1'b1;
                        ps2d_oe_r <= 1'b0;
                        tx_idle_r <= 1'b0;
                    end
                end
                RTS: begin
                    if (inh_cnt == '0) begin
                        state     <= START;
                        wd_cnt    <= '0;
                        ps2c_oe_r <= 1'b0;
                        ps2d_oe_r <= 1'b1;
                    end else begin
                        inh_cnt <= inh_cnt - 1'b1;
                    end
                end
                START, DATA, STOP, RECOVER: begin
                    // Watchdog wins over a fall arriving in the same cycle
                    if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        state     <= IDLE;
                        ps2c_oe_r <= 1'b0;
                        ps2d_oe_r <= 1'b0;
                        tx_idle_r <= 1'b1;
                        tx_err_r  <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        case (state)
                            START: begin
                                if (fall) begin
                                    state     <= DATA;
                                    bit_cnt   <= '0;
                                    ps2d_oe_r <= ~shreg[0];
                                end
                            end
                            DATA: begin
                                if (fall) begin
                                    if (bit_cnt == 4'd8) begin
                                        ps2d_oe_r <= 1'b0;
                                        state     <= STOP;
                                    end else begin
                                        shreg     <= shreg >> 1;
                                        bit_cnt   <= bit_cnt + 4'd1;
                                        ps2d_oe_r <= ~shreg[1];
                                    end
                                end
                            end
                            STOP: begin
                                if (fall) begin
                                    ack_ok <= ~ps2d_p1;
                                    state  <= RECOVER;
                                end
                            end
                            RECOVER: begin
                                if (filt_clk && ps2d_p1) begin
                                    state     <= IDLE;
                                    tx_idle_r <= 1'b1;
                                    tx_done_r <= ack_ok;
                                    tx_err_r  <= ~ack_ok;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                default: begin
                    state     <= IDLE;
                    ps2c_oe_r <= 1'b0;
                    ps2d_oe_r <= 1'b0;
                    tx_idle_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ps2c_oe = ps2c_oe_r;
    assign bus.ps2d_oe = ps2d_oe_r;
    assign bus.tx_idle = tx_idle_r;
    assign bus.tx_done = tx_done_r;
    assign bus.tx_err  = tx_err_r;
endmodule
